// File: rtl/cla_pkg.sv
// cla_pkg
// Shared definitions for the carry-look-ahead adder wrapper slice.
//   CLA_WIDTH       operand / sum width of the adder
//   CLA_LATENCY     register stages inside the pipelined adder
//   CLA_FIFO_DEPTH  default depth of the result FIFO
//   CLA_CNT_W       width of a counter that spans 0..CLA_FIFO_DEPTH
//   cla_res_t       one adder result as {cout, sum}
package cla_pkg;

  localparam int CLA_WIDTH      = 16;
  localparam int CLA_LATENCY    = 5;
  localparam int CLA_FIFO_DEPTH = 8;
  localparam int CLA_CNT_W      = $clog2(CLA_FIFO_DEPTH + 1);

  typedef struct packed {
    logic                 cout;
    logic [CLA_WIDTH-1:0] sum;
  } cla_res_t;

endpackage

// File: rtl/cla_result_fifo.sv
// cla_result_fifo
// Show-ahead synchronous FIFO that buffers adder results.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   push         write push_data at the next edge
//   push_data    entry to store
//   pop          consume the head entry at the next edge (ignored when empty)
//   head_data    head entry; holds the last popped entry while empty (0 after reset)
//   occupancy    number of stored entries, 0..DEPTH
module cla_result_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [W-1:0]     last_data;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work too.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop = pop && (occ != '0);

  // Storage array carries no reset; stale entries are never visible because
  // the empty case is served from last_data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer/occupancy bookkeeping; last_data remembers the most recently
  // popped entry so the output holds steady while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      last_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr    <= next_ptr(rd_ptr);
        last_data <= mem[rd_ptr];
      end
      occ <= occ + OCC_W'(push) - OCC_W'(do_pop);
    end
  end

  // A push is never bypassed to the output: it shows up the cycle after.
  assign head_data = (occ == '0) ? last_data : mem[rd_ptr];
  assign occupancy = occ;

  // Overflow is impossible while the upstream credit scheme is intact.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !do_pop && (occ == OCC_W'(DEPTH))));
    end
  end

endmodule

// File: rtl/cla_issue_ctrl.sv
// cla_issue_ctrl
// Flow-control wrapper around a fixed-latency, non-stallable pipelined CLA
// adder. Operands are accepted on a valid/ready interface and forwarded to the
// adder; a valid shift register follows each operation through the adder and
// its result is captured in a show-ahead FIFO drained on a valid/ready output.
// A credit counter (in-flight ops + FIFO occupancy) keeps the adder from ever
// overrunning the FIFO.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake, in_a/in_b operands
//   add_a/add_b           operands towards the adder (0 when not issuing)
//   add_res               adder result {carry, sum}
//   out_valid/out_ready   result handshake, out_sum/out_cout result
//   stat_ops/stat_stall   accepted-op and stall-cycle counters
// Build option:
//   CLA_ISSUE_STATS_EN    when defined, stat_ops/stat_stall are live 32-bit
//                         wrapping counters; otherwise both are tied to 0.
module cla_issue_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH      = CLA_WIDTH,
  parameter int LATENCY    = CLA_LATENCY,
  parameter int FIFO_DEPTH = CLA_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_stall
);

  localparam int CNT_W = (FIFO_DEPTH == CLA_FIFO_DEPTH) ? CLA_CNT_W
                                                        : $clog2(FIFO_DEPTH + 1);

  logic               fire;
  logic               pop;
  logic [LATENCY-1:0] vld_sr;
  logic [CNT_W-1:0]   credit_cnt;
  logic [WIDTH:0]     head_data;
  logic [CNT_W-1:0]   fifo_occ;

  // Readiness depends on registered credit only, so a pop at full credit
  // frees the slot one cycle later rather than through a combinational path.
  assign in_ready = !reset && (credit_cnt < CNT_W'(FIFO_DEPTH));
  assign fire     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Adder inputs are zeroed when nothing issues to keep them deterministic.
  assign add_a = fire ? in_a : '0;
  assign add_b = fire ? in_b : '0;

  // The top bit marks the cycle in which add_res holds a tracked result.
  // Clearing on reset discards whatever the adder still has in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[LATENCY-2:0], fire};
    end
  end

  // Credits are taken on issue and returned on pop; a push into the FIFO
  // just moves a credit from in-flight to occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_cnt <= '0;
    end else begin
      credit_cnt <= credit_cnt + CNT_W'(fire) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pop && !fire && (credit_cnt == '0)));
    end
  end

  cla_result_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_sr[LATENCY-1]),
    .push_data (add_res),
    .pop       (pop),
    .head_data (head_data),
    .occupancy (fifo_occ)
  );

  assign out_valid = (fifo_occ != '0);
  assign out_cout  = head_data[WIDTH];
  assign out_sum   = head_data[WIDTH-1:0];

`ifdef CLA_ISSUE_STATS_EN
  logic [31:0] ops_cnt;
  logic [31:0] stall_cnt;

  // Free-running wrap-around statistics, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ops_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (fire) begin
        ops_cnt <= ops_cnt + 32'd1;
      end
      if (in_valid && !in_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign stat_ops   = ops_cnt;
  assign stat_stall = stall_cnt;
`else
  assign stat_ops   = '0;
  assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_cla_issue_ctrl.sv
// tb_cla_issue_ctrl
// Self-checking bench for cla_issue_ctrl. Contains a behavioural model of the
// pipelined adder feeding add_res, plus a reference model of expected results
// (a queue of a+b values) and outstanding credit (accepted minus consumed).
module tb_cla_issue_ctrl;
  import cla_pkg::*;

  localparam int WIDTH      = CLA_WIDTH;
  localparam int LATENCY    = CLA_LATENCY;
  localparam int FIFO_DEPTH = CLA_FIFO_DEPTH;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_res;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [31:0]      stat_ops;
  logic [31:0]      stat_stall;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int outstanding = 0;
  int stall_model = 0;
  logic [WIDTH:0] exp_q[$];

  cla_issue_ctrl #(
    .WIDTH      (WIDTH),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_res    (add_res),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_cout   (out_cout),
    .stat_ops   (stat_ops),
    .stat_stall (stat_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Pipelined adder: operands sampled at one edge, sum visible after
  // LATENCY-1 further edges.
  logic [WIDTH:0] pipe [LATENCY];
  initial for (int i = 0; i < LATENCY; i++) pipe[i] = '0;
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign add_res = pipe[LATENCY-1];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  // Reference model: every accepted pair queues its true sum; every consumed
  // result must be the oldest queued sum. Credit = accepted - consumed.
  always @(negedge clk) begin
    cla_res_t e;
    if (reset) begin
      exp_q.delete();
      outstanding = 0;
      stall_model = 0;
      checkOutput("in_ready_during_reset", in_ready, 0);
    end else begin
      checkOutput("in_ready", in_ready, (outstanding < FIFO_DEPTH) ? 1 : 0);
      checkOutput("add_a", add_a, (in_valid && in_ready) ? in_a : 16'h0);
      checkOutput("add_b", add_b, (in_valid && in_ready) ? in_b : 16'h0);
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
        outstanding++;
      end
      if (in_valid && !in_ready) stall_model++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out_valid", out_valid, 0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          checkOutput("result", {out_cout, out_sum}, e);
          outstanding--;
        end
      end
    end
  end

  // Present one operand pair (called just after a rising edge) and wait,
  // bounded, until it is accepted. Leaves in_valid asserted.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               output int waited);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) checkOutput("accept_timeout", 0, 1);
    accept_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 200) checkOutput("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int w;
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_sum", out_sum, 0);
    checkOutput("rst_out_cout", out_cout, 0);
    checkOutput("rst_stat_ops", stat_ops, 0);
    checkOutput("rst_stat_stall", stat_stall, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single op and its latency
    out_ready = 1'b1;
    applyStimulus(16'h1234, 16'h0001, w);
    in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput("single_latency", cyc - accept_cyc, LATENCY + 1);
    checkOutput("single_sum", out_sum, 16'h1235);
    checkOutput("single_cout", out_cout, 0);
    @(negedge clk);
    checkOutput("single_popped", out_valid, 0);
    @(posedge clk);
    #1;

    // Carry cases; output holds the last result once empty
    applyStimulus(16'hFFFF, 16'h0001, w);
    applyStimulus(16'h8000, 16'h8000, w);
    in_valid = 1'b0;
    waitDrain();
    checkOutput("hold_sum", out_sum, 16'h0000);
    checkOutput("hold_cout", out_cout, 1);

    // Reset while three ops are in flight
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) applyStimulus(16'($urandom), 16'($urandom), w);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", in_ready, 1);
    checkOutput("post_reset_stat_ops", stat_ops, 0);
    for (int i = 0; i < 15; i++) begin
      checkOutput("flushed_out_valid", out_valid, 0);
      @(negedge clk);
    end

    // Backpressure: 8 accepts fill the credit, then stall until draining
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(16'(i), 16'h0100, w);
    in_a = 16'd8;
    in_b = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", in_ready, 0);
    end
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_head", out_sum, 16'h0100);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 8; i < 12; i++) applyStimulus(16'(i), 16'h0100, w);
    in_valid = 1'b0;
    waitDrain();
`ifdef CLA_ISSUE_STATS_EN
    checkOutput("stat_ops", stat_ops, 12);
    checkOutput("stat_stall", stat_stall, stall_model);
`else
    checkOutput("stat_ops_off", stat_ops, 0);
    checkOutput("stat_stall_off", stat_stall, 0);
`endif

    // Full throughput with random operands
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), w);
      checkOutput("tput_no_stall", w, 0);
    end
    in_valid = 1'b0;
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
